fifo_parity_scoreboard: RTL and testbench
=========================================

Name: fifo_parity_scoreboard

Overview:
- Synthesizable in-line scoreboard that snoops both handshakes of a parity-protected FIFO.
- Classifies every pushed and popped word by parity, and keeps a shadow queue of good pushed words.
- Compares each good popped word against that queue, with optional one-word loss tolerance.
- Exposes saturating statistics, sticky error flags and a halt-on-fail mode. Sits beside the FIFO in both simulation and FPGA debug builds.

Parameters:
- DATA_WIDTH, 17: bits per word, including the parity bit.
- DEPTH, 4: shadow queue entries; power of two, >= 2.
- PARITY, 1'b1: 1 = EVEN (word valid when XOR of all bits is 0); 0 = ODD (valid when XOR is 1).
- P_BIT, 1'b1: parity bit position; 1 = LSB, 0 = MSB. Used for payload stripping.
- LOSS_TOL, 1'b1: 1 = a mismatch may be resolved against the head+1 entry.
- STOP_ON_FAIL, 1'b0: 1 = freeze all state after the first fail.
- CNT_WIDTH, 16: width of each statistic counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- valid_in  in  1  producer valid toward the FIFO
- grant_out  in  1  FIFO ready toward the producer
- data_in  in  DATA_WIDTH  pushed word
- valid_out  in  1  FIFO valid toward the consumer
- grant_in  in  1  consumer ready toward the FIFO
- data_out  in  DATA_WIDTH  popped word
- clear  in  1  synchronous clear of counters, flags, queue and state
- pass_cnt, fail_cnt  out  CNT_WIDTH  compare results
- push_ok_cnt, push_err_cnt  out  CNT_WIDTH  pushes with good / bad parity
- pop_ok_cnt, pop_err_cnt  out  CNT_WIDTH  pops with good / bad parity
- occupancy  out  $clog2(DEPTH)+1  shadow queue fill level
- overflow, underflow  out  1  sticky flags
- fail_pulse  out  1  one-cycle strobe per fail event
- halted  out  1  high in state HALT
- last_fail_payload  out  DATA_WIDTH-1  payload of the most recent failing pop, parity bit stripped

Behaviour:
- Reset (rst_n=0 at posedge clk) and clear=1 have identical effect:
  - all counters, occupancy, flags, fail_pulse, halted and last_fail_payload go to 0;
  - shadow queue is emptied; state goes to RUN.
  - Reset takes priority over every other event in that cycle.
- Event definitions: push = valid_in & grant_out; pop = valid_out & grant_in. Both are sampled at posedge clk. Every output is registered and reflects the event one cycle later.
- Parity check: good = (^word) == ~PARITY.
- Push handling:
  - good push: push_ok_cnt+1 and the word is enqueued;
  - bad push: push_err_cnt+1, nothing is enqueued;
  - good push with occupancy==DEPTH (and no same-cycle dequeue): word dropped, overflow set.
- Pop handling (compares against the queue contents before this cycle's push):
  - bad parity pop: pop_err_cnt+1, fail_cnt+1, last_fail_payload captured, queue untouched.
  - good pop with empty queue: pop_ok_cnt+1, fail_cnt+1, underflow set.
  - good pop equal to head: pop_ok_cnt+1, pass_cnt+1, dequeue 1.
  - good pop not equal to head, LOSS_TOL=1, occupancy>=2, equal to head+1: fail_cnt+1 (lost word), pass_cnt+1, dequeue 2.
  - any other good pop: fail_cnt+1, dequeue 1, last_fail_payload captured.
- Simultaneous push and pop at full: the dequeue frees space, so the push is enqueued and no overflow is raised.
- Counters saturate at all-ones. A fail_cnt increment of 1 per cycle is enough; the loss case adds 1.
- Payload stripping: P_BIT=1 takes data[DATA_WIDTH-1:1]; P_BIT=0 takes data[DATA_WIDTH-2:0].
- State machine:
  - RUN -> HALT on any fail event when STOP_ON_FAIL=1.
  - HALT ignores all events; outputs hold their values; halted=1.
  - HALT -> RUN only on reset or clear.

Decomposition:
- Shared package fifo_chk_pkg holds:
  - enum chk_state_t {RUN, HALT};
  - function parity_ok(word, PARITY);
  - enum pop_result_t {RES_PASS, RES_LOSS_PASS, RES_MISMATCH, RES_UNDERFLOW, RES_PERR}.
- One sub-module, chk_shadow_fifo:
  - circular buffer of DEPTH entries;
  - combinational head and head+1 peek;
  - dequeue of 0, 1 or 2 entries plus enqueue in the same cycle;
  - occupancy output;
  - synchronous active-low reset and clear.

Test Plan:
- Defaults (DATA_WIDTH=17, EVEN, LSB). Push 17'h00003, 17'h00005, 17'h00006, then pop them in order -> pass_cnt=3, fail_cnt=0, push_ok_cnt=3, occupancy=0.
- Push 17'h00001 (odd number of ones), then pop 17'h00001 -> push_err_cnt=1, pop_err_cnt=1, fail_cnt=1, last_fail_payload=16'h0000, fail_pulse high for exactly 1 cycle.
- Push 17'h00003 then 17'h00005; pop 17'h00005 only -> fail_cnt=1, pass_cnt=1, occupancy=0. Repeat with LOSS_TOL=0 -> fail_cnt=1, pass_cnt=0, occupancy=1.
- Push 5 good words with DEPTH=4 and no pops -> occupancy=4, overflow=1. At full, push and pop in the same cycle -> occupancy stays 4 and overflow does not re-trigger.
- Pop 17'h00003 with the queue empty -> underflow=1, fail_cnt=1. With STOP_ON_FAIL=1 -> halted=1 and later pushes/pops leave every counter unchanged; clear=1 for one cycle -> all zero, halted=0.
- Drop rst_n low for one posedge in the middle of a push/pop stream with occupancy=3 -> all outputs 0 in the next cycle; traffic afterwards starts from an empty queue.

Source files
------------

// File: rtl/fifo_parity_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : fifo_chk_pkg
//  Description : Shared types and parity helper for the FIFO parity scoreboard
//  Revision    : 1.0  initial release
// ============================================================================
package fifo_chk_pkg;

    // Widest word the parity helper accepts; narrower words are zero-extended,
    // which leaves their XOR reduction unchanged.
    localparam int MAX_WORD_W = 64;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HALT = 1'b1
    } chk_state_t;

    typedef enum logic [2:0] {
        RES_NONE      = 3'd0,
        RES_PASS      = 3'd1,
        RES_LOSS_PASS = 3'd2,
        RES_MISMATCH  = 3'd3,
        RES_UNDERFLOW = 3'd4,
        RES_PERR      = 3'd5
    } pop_result_t;

    // parity=1 selects EVEN (good when XOR is 0), parity=0 selects ODD
    function automatic logic parity_ok(input logic [MAX_WORD_W-1:0] word,
                                       input logic                  parity);
        return (^word) == ~parity;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_parity_scoreboard_shadow.sv
`default_nettype none
// ============================================================================
//  Module      : chk_shadow_fifo
//  Description : Circular shadow queue with head / head+1 peek, dequeue of
//                0..2 entries and one enqueue per cycle
//  Revision    : 1.0  initial release
// ============================================================================
module chk_shadow_fifo #(
    parameter int DATA_WIDTH = 17,
    parameter int DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       enq,
    input  logic [DATA_WIDTH-1:0]      enq_data,
    input  logic [1:0]                 deq_cnt,
    output logic [DATA_WIDTH-1:0]      head,
    output logic [DATA_WIDTH-1:0]      head_next,
    output logic [$clog2(DEPTH):0]     occupancy
);
    localparam int c_aw = $clog2(DEPTH);
    localparam int c_ow = c_aw + 1;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]       r_rd_ptr;
    logic [c_aw-1:0]       r_wr_ptr;
    logic [c_ow-1:0]       r_occ;

    // Pointers wrap naturally because DEPTH is a power of two
    assign head      = r_mem[r_rd_ptr];
    assign head_next = r_mem[r_rd_ptr + c_aw'(1)];
    assign occupancy = r_occ;

    // Storage write; a write at full lands on the slot being dequeued
    always_ff @(posedge clk) begin
        if (enq) begin
            r_mem[r_wr_ptr] <= enq_data;
        end
    end

    // Pointer and fill-level bookkeeping
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_occ    <= '0;
        end else begin
            r_rd_ptr <= r_rd_ptr + c_aw'(deq_cnt);
            if (enq) begin
                r_wr_ptr <= r_wr_ptr + c_aw'(1);
            end
            r_occ <= r_occ + c_ow'(enq) - c_ow'(deq_cnt);
        end
    end

endmodule
`default_nettype wire

// File: rtl/fifo_parity_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_parity_scoreboard
//  Description : In-line scoreboard for a parity-protected FIFO: classifies
//                pushes/pops, compares pops with a shadow queue, keeps
//                saturating statistics and sticky flags, optional halt
//  Revision    : 1.0  initial release
// ============================================================================
module fifo_parity_scoreboard
    import fifo_chk_pkg::*;
#(
    parameter int   DATA_WIDTH   = 17,
    parameter int   DEPTH        = 4,
    parameter logic PARITY       = 1'b1,
    parameter logic P_BIT        = 1'b1,
    parameter logic LOSS_TOL     = 1'b1,
    parameter logic STOP_ON_FAIL = 1'b0,
    parameter int   CNT_WIDTH    = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    valid_in,
    input  logic                    grant_out,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic                    valid_out,
    input  logic                    grant_in,
    input  logic [DATA_WIDTH-1:0]   data_out,
    input  logic                    clear,
    output logic [CNT_WIDTH-1:0]    pass_cnt,
    output logic [CNT_WIDTH-1:0]    fail_cnt,
    output logic [CNT_WIDTH-1:0]    push_ok_cnt,
    output logic [CNT_WIDTH-1:0]    push_err_cnt,
    output logic [CNT_WIDTH-1:0]    pop_ok_cnt,
    output logic [CNT_WIDTH-1:0]    pop_err_cnt,
    output logic [$clog2(DEPTH):0]  occupancy,
    output logic                    overflow,
    output logic                    underflow,
    output logic                    fail_pulse,
    output logic                    halted,
    output logic [DATA_WIDTH-2:0]   last_fail_payload
);
    localparam int c_ow = $clog2(DEPTH) + 1;

    chk_state_t            r_state;
    chk_state_t            w_state_nxt;
    pop_result_t           w_res;
    logic [1:0]            w_deq;
    logic [DATA_WIDTH-1:0] w_head;
    logic [DATA_WIDTH-1:0] w_head_next;
    logic [c_ow-1:0]       w_occ;
    logic [DATA_WIDTH-2:0] w_payload;

    logic [CNT_WIDTH-1:0]  r_pass, r_fail, r_push_ok, r_push_err, r_pop_ok, r_pop_err;
    logic                  r_overflow, r_underflow, r_fail_pulse;
    logic [DATA_WIDTH-2:0] r_lfp;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    // Events are only acted on while running; HALT freezes everything
    wire w_run       = (r_state == RUN);
    wire w_push      = w_run & valid_in & grant_out;
    wire w_pop       = w_run & valid_out & grant_in;
    wire w_push_good = parity_ok(MAX_WORD_W'(data_in), PARITY);
    wire w_pop_good  = parity_ok(MAX_WORD_W'(data_out), PARITY);

    generate
        if (P_BIT == 1'b1) begin : g_pbit_lsb
            assign w_payload = data_out[DATA_WIDTH-1:1];
        end else begin : g_pbit_msb
            assign w_payload = data_out[DATA_WIDTH-2:0];
        end
    endgenerate

    // Classify the pop against the queue contents before this cycle's push
    always_comb begin
        w_res = RES_NONE;
        w_deq = 2'd0;
        if (w_pop) begin
            if (!w_pop_good) begin
                w_res = RES_PERR;
            end else if (w_occ == '0) begin
                w_res = RES_UNDERFLOW;
            end else if (data_out == w_head) begin
                w_res = RES_PASS;
                w_deq = 2'd1;
            end else if (LOSS_TOL && (w_occ >= c_ow'(2)) && (data_out == w_head_next)) begin
                w_res = RES_LOSS_PASS;
                w_deq = 2'd2;
            end else begin
                w_res = RES_MISMATCH;
                w_deq = 2'd1;
            end
        end
    end

    // Space is judged after this cycle's dequeue so push+pop at full is accepted
    wire w_space    = (w_occ - c_ow'(w_deq)) < c_ow'(DEPTH);
    wire w_push_ok  = w_push & w_push_good;
    wire w_enq      = w_push_ok & w_space;
    wire w_ovf      = w_push_ok & ~w_space;
    wire w_pass_evt = (w_res == RES_PASS) || (w_res == RES_LOSS_PASS);
    wire w_fail_evt = (w_res != RES_NONE) && (w_res != RES_PASS);
    wire w_capture  = (w_res == RES_PERR) || (w_res == RES_MISMATCH);

    chk_shadow_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_shadow (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .enq        (w_enq),
        .enq_data   (data_in),
        .deq_cnt    (w_deq),
        .head       (w_head),
        .head_next  (w_head_next),
        .occupancy  (w_occ)
    );

    // State register; reset and clear both return to RUN
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: leave RUN on the first fail when halting is enabled
    always_comb begin
        w_state_nxt = r_state;
        if ((r_state == RUN) && w_fail_evt && STOP_ON_FAIL) begin
            w_state_nxt = HALT;
        end
    end

    // Statistics, sticky flags, fail strobe and failing payload capture
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            r_pass       <= '0;
            r_fail       <= '0;
            r_push_ok    <= '0;
            r_push_err   <= '0;
            r_pop_ok     <= '0;
            r_pop_err    <= '0;
            r_overflow   <= 1'b0;
            r_underflow  <= 1'b0;
            r_fail_pulse <= 1'b0;
            r_lfp        <= '0;
        end else begin
            r_fail_pulse <= w_fail_evt;
            if (w_pass_evt)                r_pass     <= sat_inc(r_pass);
            if (w_fail_evt)                r_fail     <= sat_inc(r_fail);
            if (w_push_ok)                 r_push_ok  <= sat_inc(r_push_ok);
            if (w_push && !w_push_good)    r_push_err <= sat_inc(r_push_err);
            if (w_pop && w_pop_good)       r_pop_ok   <= sat_inc(r_pop_ok);
            if (w_res == RES_PERR)         r_pop_err  <= sat_inc(r_pop_err);
            if (w_ovf)                     r_overflow <= 1'b1;
            if (w_res == RES_UNDERFLOW)    r_underflow <= 1'b1;
            if (w_capture)                 r_lfp      <= w_payload;
        end
    end

    assign pass_cnt          = r_pass;
    assign fail_cnt          = r_fail;
    assign push_ok_cnt       = r_push_ok;
    assign push_err_cnt      = r_push_err;
    assign pop_ok_cnt        = r_pop_ok;
    assign pop_err_cnt       = r_pop_err;
    assign occupancy         = w_occ;
    assign overflow          = r_overflow;
    assign underflow         = r_underflow;
    assign fail_pulse        = r_fail_pulse;
    assign halted            = (r_state == HALT);
    assign last_fail_payload = r_lfp;

endmodule
`default_nettype wire

// File: tb/tb_fifo_parity_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_parity_scoreboard
//  Description : Self-checking bench for fifo_parity_scoreboard; three
//                instances (default, no loss tolerance, halt on fail) share
//                one stimulus stream and are compared with a queue model
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fifo_parity_scoreboard;
    localparam int NI  = 3;
    localparam int DEP = 4;

    logic        clk = 1'b0;
    logic        rst_n, valid_in, grant_out, valid_out, grant_in, clear;
    logic [16:0] data_in, data_out;

    logic [15:0] pass_cnt [NI];
    logic [15:0] fail_cnt [NI];
    logic [15:0] push_ok_cnt [NI];
    logic [15:0] push_err_cnt [NI];
    logic [15:0] pop_ok_cnt [NI];
    logic [15:0] pop_err_cnt [NI];
    logic [2:0]  occupancy [NI];
    logic        overflow [NI];
    logic        underflow [NI];
    logic        fail_pulse [NI];
    logic        halted [NI];
    logic [15:0] last_fail_payload [NI];

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [16:0] mq [NI][$];
    int   m_pass [NI], m_fail [NI], m_pok [NI], m_perr [NI], m_ook [NI], m_oerr [NI];
    bit   m_ovf [NI], m_udf [NI], m_pulse [NI], m_halt [NI];
    logic [15:0] m_lfp [NI];
    bit   m_loss [NI];
    bit   m_stop [NI];

    always #5 clk = ~clk;

    fifo_parity_scoreboard u_dut0 (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .grant_out(grant_out), .data_in(data_in),
        .valid_out(valid_out), .grant_in(grant_in), .data_out(data_out), .clear(clear),
        .pass_cnt(pass_cnt[0]), .fail_cnt(fail_cnt[0]), .push_ok_cnt(push_ok_cnt[0]),
        .push_err_cnt(push_err_cnt[0]), .pop_ok_cnt(pop_ok_cnt[0]), .pop_err_cnt(pop_err_cnt[0]),
        .occupancy(occupancy[0]), .overflow(overflow[0]), .underflow(underflow[0]),
        .fail_pulse(fail_pulse[0]), .halted(halted[0]), .last_fail_payload(last_fail_payload[0]));

    fifo_parity_scoreboard #(.LOSS_TOL(1'b0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .grant_out(grant_out), .data_in(data_in),
        .valid_out(valid_out), .grant_in(grant_in), .data_out(data_out), .clear(clear),
        .pass_cnt(pass_cnt[1]), .fail_cnt(fail_cnt[1]), .push_ok_cnt(push_ok_cnt[1]),
        .push_err_cnt(push_err_cnt[1]), .pop_ok_cnt(pop_ok_cnt[1]), .pop_err_cnt(pop_err_cnt[1]),
        .occupancy(occupancy[1]), .overflow(overflow[1]), .underflow(underflow[1]),
        .fail_pulse(fail_pulse[1]), .halted(halted[1]), .last_fail_payload(last_fail_payload[1]));

    fifo_parity_scoreboard #(.STOP_ON_FAIL(1'b1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .grant_out(grant_out), .data_in(data_in),
        .valid_out(valid_out), .grant_in(grant_in), .data_out(data_out), .clear(clear),
        .pass_cnt(pass_cnt[2]), .fail_cnt(fail_cnt[2]), .push_ok_cnt(push_ok_cnt[2]),
        .push_err_cnt(push_err_cnt[2]), .pop_ok_cnt(pop_ok_cnt[2]), .pop_err_cnt(pop_err_cnt[2]),
        .occupancy(occupancy[2]), .overflow(overflow[2]), .underflow(underflow[2]),
        .fail_pulse(fail_pulse[2]), .halted(halted[2]), .last_fail_payload(last_fail_payload[2]));

    // EVEN parity, parity bit in the LSB
    function automatic logic [16:0] good_w(input logic [15:0] p);
        return {p, ^p};
    endfunction

    function automatic logic [16:0] bad_w(input logic [15:0] p);
        return {p, ~(^p)};
    endfunction

    function automatic int sinc(input int v);
        return (v >= 65535) ? v : v + 1;
    endfunction

    task automatic chk(input string tag, input int inst, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, inst, obs, exp);
        end
    endtask

    // Model: one clock edge of every instance, from the scoreboard rules
    task automatic model_step();
        for (int i = 0; i < NI; i++) begin
            bit f;
            int nd;
            int sz;
            f  = 0;
            nd = 0;
            sz = mq[i].size();
            if (!rst_n || clear) begin
                mq[i].delete();
                m_pass[i] = 0; m_fail[i] = 0; m_pok[i] = 0; m_perr[i] = 0; m_ook[i] = 0; m_oerr[i] = 0;
                m_ovf[i] = 0; m_udf[i] = 0; m_pulse[i] = 0; m_halt[i] = 0; m_lfp[i] = '0;
            end else if (m_halt[i]) begin
                m_pulse[i] = 0;
            end else begin
                if (valid_out && grant_in) begin
                    if (^data_out) begin
                        m_oerr[i] = sinc(m_oerr[i]); m_fail[i] = sinc(m_fail[i]);
                        m_lfp[i] = data_out[16:1]; f = 1;
                    end else begin
                        m_ook[i] = sinc(m_ook[i]);
                        if (sz == 0) begin
                            m_fail[i] = sinc(m_fail[i]); m_udf[i] = 1; f = 1;
                        end else if (data_out == mq[i][0]) begin
                            m_pass[i] = sinc(m_pass[i]); nd = 1;
                        end else if (m_loss[i] && sz >= 2 && data_out == mq[i][1]) begin
                            m_pass[i] = sinc(m_pass[i]); m_fail[i] = sinc(m_fail[i]); nd = 2; f = 1;
                        end else begin
                            m_fail[i] = sinc(m_fail[i]); nd = 1; m_lfp[i] = data_out[16:1]; f = 1;
                        end
                    end
                end
                repeat (nd) void'(mq[i].pop_front());
                if (valid_in && grant_out) begin
                    if (^data_in) begin
                        m_perr[i] = sinc(m_perr[i]);
                    end else begin
                        m_pok[i] = sinc(m_pok[i]);
                        if (mq[i].size() < DEP) mq[i].push_back(data_in);
                        else m_ovf[i] = 1;
                    end
                end
                m_pulse[i] = f;
                if (f && m_stop[i]) m_halt[i] = 1;
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < NI; i++) begin
            chk("pass_cnt", i, 32'(pass_cnt[i]), m_pass[i]);
            chk("fail_cnt", i, 32'(fail_cnt[i]), m_fail[i]);
            chk("push_ok_cnt", i, 32'(push_ok_cnt[i]), m_pok[i]);
            chk("push_err_cnt", i, 32'(push_err_cnt[i]), m_perr[i]);
            chk("pop_ok_cnt", i, 32'(pop_ok_cnt[i]), m_ook[i]);
            chk("pop_err_cnt", i, 32'(pop_err_cnt[i]), m_oerr[i]);
            chk("occupancy", i, 32'(occupancy[i]), mq[i].size());
            chk("overflow", i, 32'(overflow[i]), 32'(m_ovf[i]));
            chk("underflow", i, 32'(underflow[i]), 32'(m_udf[i]));
            chk("fail_pulse", i, 32'(fail_pulse[i]), 32'(m_pulse[i]));
            chk("halted", i, 32'(halted[i]), 32'(m_halt[i]));
            chk("last_fail_payload", i, 32'(last_fail_payload[i]), 32'(m_lfp[i]));
        end
    endtask

    // Apply one cycle of inputs, advance the model, compare after the edge
    task automatic drive(input logic vi, input logic go, input logic [16:0] di,
                         input logic vo, input logic gi, input logic [16:0] dout,
                         input logic clr, input logic rn);
        @(negedge clk);
        valid_in = vi; grant_out = go; data_in = di;
        valid_out = vo; grant_in = gi; data_out = dout;
        clear = clr; rst_n = rn;
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic push(input logic [16:0] w);  drive(1, 1, w, 0, 0, '0, 0, 1); endtask
    task automatic pop(input logic [16:0] w);   drive(0, 0, '0, 1, 1, w, 0, 1); endtask
    task automatic idle();                      drive(0, 0, '0, 0, 0, '0, 0, 1); endtask
    task automatic do_clear();                  drive(0, 0, '0, 0, 0, '0, 1, 1); endtask

    initial begin
        logic [16:0] pw;
        logic [16:0] ow;
        m_loss = '{1, 0, 1};
        m_stop = '{0, 0, 1};
        valid_in = 0; grant_out = 0; data_in = '0; valid_out = 0; grant_in = 0; data_out = '0;
        clear = 0; rst_n = 0;

        // Reset state
        drive(0, 0, '0, 0, 0, '0, 0, 0);
        drive(1, 1, 17'h00003, 1, 1, 17'h00003, 0, 0);
        chk("rst_occ", 0, 32'(occupancy[0]), 0);

        // In-order traffic
        push(17'h00003); push(17'h00005); push(17'h00006);
        pop(17'h00003);  pop(17'h00005);  pop(17'h00006);
        chk("inorder_pass", 0, 32'(pass_cnt[0]), 3);
        chk("inorder_fail", 0, 32'(fail_cnt[0]), 0);
        chk("inorder_push_ok", 0, 32'(push_ok_cnt[0]), 3);
        chk("inorder_occ", 0, 32'(occupancy[0]), 0);

        // Bad parity on both sides
        do_clear();
        push(17'h00001);
        pop(17'h00001);
        chk("perr_pulse_hi", 0, 32'(fail_pulse[0]), 1);
        chk("perr_lfp", 0, 32'(last_fail_payload[0]), 0);
        idle();
        chk("perr_pulse_lo", 0, 32'(fail_pulse[0]), 0);
        chk("perr_fail", 0, 32'(fail_cnt[0]), 1);
        chk("perr_push_err", 0, 32'(push_err_cnt[0]), 1);
        chk("perr_pop_err", 0, 32'(pop_err_cnt[0]), 1);

        // Lost word, with and without tolerance
        do_clear();
        push(17'h00003); push(17'h00005); pop(17'h00005);
        chk("loss_fail", 0, 32'(fail_cnt[0]), 1);
        chk("loss_pass", 0, 32'(pass_cnt[0]), 1);
        chk("loss_occ", 0, 32'(occupancy[0]), 0);
        chk("noloss_fail", 1, 32'(fail_cnt[1]), 1);
        chk("noloss_pass", 1, 32'(pass_cnt[1]), 0);
        chk("noloss_occ", 1, 32'(occupancy[1]), 1);

        // Overflow, then push+pop at full
        do_clear();
        for (int k = 0; k < 5; k++) push(good_w(16'($urandom)));
        chk("ovf_occ", 0, 32'(occupancy[0]), 4);
        chk("ovf_flag", 0, 32'(overflow[0]), 1);
        pw = good_w(16'($urandom));
        drive(1, 1, pw, 1, 1, mq[0][0], 0, 1);
        chk("full_pp_occ", 0, 32'(occupancy[0]), 4);

        // Underflow and halt-on-fail
        do_clear();
        pop(17'h00003);
        chk("udf_flag", 0, 32'(underflow[0]), 1);
        chk("udf_fail", 0, 32'(fail_cnt[0]), 1);
        chk("halt_set", 2, 32'(halted[2]), 1);
        push(17'h00003); pop(17'h00003); push(17'h00001); pop(17'h00005);
        chk("halt_frozen_push", 2, 32'(push_ok_cnt[2]), 0);
        do_clear();
        chk("halt_cleared", 2, 32'(halted[2]), 0);

        // Reset in the middle of traffic at occupancy 3
        push(17'h00003); push(17'h00005); push(17'h00006);
        chk("mid_occ", 0, 32'(occupancy[0]), 3);
        drive(1, 1, 17'h0000c, 1, 1, 17'h00003, 0, 0);
        chk("mid_rst_occ", 0, 32'(occupancy[0]), 0);
        push(17'h00009); pop(17'h00009);
        chk("post_rst_pass", 0, 32'(pass_cnt[0]), 1);

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            int r;
            pw = ($urandom_range(0, 9) < 8) ? good_w(16'($urandom)) : bad_w(16'($urandom));
            r  = $urandom_range(0, 9);
            if (r <= 5 && mq[0].size() > 0)      ow = mq[0][0];
            else if (r == 6 && mq[0].size() > 1) ow = mq[0][1];
            else if (r == 7)                     ow = bad_w(16'($urandom));
            else                                 ow = good_w(16'($urandom));
            drive(1'($urandom), 1'($urandom), pw, 1'($urandom), 1'($urandom), ow,
                  ($urandom_range(0, 59) == 0), ($urandom_range(0, 149) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
